// File: rtl/prio_req_arbiter.sv
// Four-line request arbiter: latches request events into a pending register and
// hands the highest-index unmasked line to a consumer over valid/ready.
//
// state | meaning
// IDLE  | no grant outstanding; grants sel on the next edge when any_pend
// BUSY  | out_id presented and held until out_ready
module prio_req_arbiter #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  input  logic       out_ready,
  input  logic       ovf_clr,
  output logic       out_valid,
  output logic [1:0] out_id,
  output logic       any_pend,
  output logic [3:0] pending,
  output logic [3:0] ovf
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0] state;
  logic [3:0] req_d;
  logic [3:0] ev;
  logic [3:0] clr;
  logic [3:0] elig;
  logic [3:0] pend_nxt;
  logic [3:0] ovf_set;
  logic [1:0] sel;

  // A new event on a bit being serviced this cycle re-sets it, so it is not lost.
  always_comb begin
    ev = EDGE ? (req & ~req_d) : req;
    clr = 4'b0000;
    if (out_valid && out_ready) clr[out_id] = 1'b1;
    pend_nxt = (pending & ~clr) | ev;
    ovf_set  = EDGE ? (ev & pending & ~clr) : 4'b0000;
    elig = pending & ~mask;
    sel = 2'd0;
    if (elig[3])      sel = 2'd3;
    else if (elig[2]) sel = 2'd2;
    else if (elig[1]) sel = 2'd1;
    else              sel = 2'd0;
  end

  assign any_pend  = |elig;
  assign out_valid = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      out_id  <= 2'd0;
      req_d   <= 4'b0000;
      pending <= 4'b0000;
      ovf     <= 4'b0000;
    end else begin
      req_d   <= req;
      pending <= pend_nxt;
      ovf     <= (ovf & ~{4{ovf_clr}}) | ovf_set;
      case (state)
        IDLE: begin
          if (any_pend) begin
            out_id <= sel;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_req_arbiter.sv
// Directed bench for prio_req_arbiter: grants are checked by a scoreboard monitor,
// register state by direct checks in the stimulus thread. A second EDGE=0 instance covers level mode.
module tb_prio_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] mask = 4'b0000;
  logic       out_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       out_valid;
  logic [1:0] out_id;
  logic       any_pend;
  logic [3:0] pending;
  logic [3:0] ovf;

  logic [3:0] req1 = 4'b0000;
  logic       out_ready1 = 1'b0;
  logic       out_valid1;
  logic [1:0] out_id1;
  logic       any_pend1;
  logic [3:0] pending1;
  logic [3:0] ovf1;

  int checks = 0;
  int failures = 0;
  int expq[$];
  logic       prev_valid = 1'b0;
  logic [1:0] prev_id = 2'd0;

  always #5 clk = ~clk;

  prio_req_arbiter #(.EDGE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .out_ready(out_ready),
    .ovf_clr(ovf_clr), .out_valid(out_valid), .out_id(out_id),
    .any_pend(any_pend), .pending(pending), .ovf(ovf)
  );

  prio_req_arbiter #(.EDGE(1'b0)) dut_lvl (
    .clk(clk), .rst_n(rst_n), .req(req1), .mask(4'b0000), .out_ready(out_ready1),
    .ovf_clr(1'b0), .out_valid(out_valid1), .out_id(out_id1),
    .any_pend(any_pend1), .pending(pending1), .ovf(ovf1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted grant must match the next queued id.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_grant", int'(out_id), -1);
      end else begin
        chk("grant_id", int'(out_id), expq.pop_front());
      end
    end
    if (rst_n && prev_valid && out_valid) chk("hold_id", int'(out_id), int'(prev_id));
    prev_valid <= rst_n && out_valid && !out_ready;
    prev_id    <= out_id;
  end

  initial begin
    int budget;
    // Reset state
    tick(2);
    chk("rst_valid", out_valid, 0);
    chk("rst_id", out_id, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    // Reset mid-BUSY
    req = 4'b0100;
    budget = 10;
    while (!out_valid && budget > 0) begin
      tick();
      budget--;
    end
    chk("busy_reached", out_valid, 1);
    chk("busy_id", out_id, 2);
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_pending", pending, 0);
    chk("async_rst_ovf", ovf, 0);
    #3;
    rst_n = 1'b1;
    tick();

    // Priority and latency
    out_ready = 1'b1;
    req = 4'b1010;
    expq.push_back(3);
    expq.push_back(1);
    tick();
    chk("lat_e0_pending", pending, 4'b1010);
    chk("lat_e0_valid", out_valid, 0);
    tick();
    chk("lat_e1_valid", out_valid, 1);
    chk("lat_e1_id", out_id, 3);
    tick();
    chk("lat_e2_valid", out_valid, 0);
    chk("lat_e2_pending", pending, 4'b0010);
    tick();
    chk("lat_e3_valid", out_valid, 1);
    chk("lat_e3_id", out_id, 1);
    tick();
    chk("lat_e4_valid", out_valid, 0);
    chk("lat_e4_pending", pending, 4'b0000);
    req = 4'b0000;
    tick();

    // Hold stability
    out_ready = 1'b0;
    req = 4'b0001;
    tick(2);
    chk("hold_valid", out_valid, 1);
    chk("hold_id0", out_id, 0);
    req = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_stable_id", out_id, 0);
      chk("hold_stable_valid", out_valid, 1);
    end
    chk("hold_pending", pending, 4'b1001);
    expq.push_back(0);
    expq.push_back(3);
    out_ready = 1'b1;
    tick();
    chk("hold_acc_valid", out_valid, 0);
    chk("hold_acc_pending", pending, 4'b1000);
    tick();
    chk("hold_next_id", out_id, 3);
    chk("hold_next_valid", out_valid, 1);
    tick();
    chk("hold_done_pending", pending, 4'b0000);
    req = 4'b0000;
    tick();

    // Masking
    mask = 4'b1000;
    req = 4'b1001;
    expq.push_back(0);
    tick();
    chk("mask_pending", pending, 4'b1001);
    chk("mask_any", any_pend, 1);
    tick();
    chk("mask_grant_id", out_id, 0);
    tick();
    chk("mask_after_pending", pending, 4'b1000);
    chk("mask_after_any", any_pend, 0);
    tick();
    chk("mask_idle_valid", out_valid, 0);
    mask = 4'b0000;
    expq.push_back(3);
    #1;
    chk("unmask_any", any_pend, 1);
    tick();
    chk("unmask_valid", out_valid, 1);
    chk("unmask_id", out_id, 3);
    tick();
    chk("unmask_pending", pending, 4'b0000);
    req = 4'b0000;
    tick();

    // Overrun and set-wins
    out_ready = 1'b0;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    chk("ovr_first_ovf", ovf, 0);
    req = 4'b0100;
    tick();
    chk("ovr_ovf", ovf, 4'b0100);
    tick(3);
    chk("ovr_sticky", ovf, 4'b0100);
    ovf_clr = 1'b1;
    tick();
    chk("ovr_clr", ovf, 4'b0000);
    ovf_clr = 1'b0;
    req = 4'b0000;
    tick();
    chk("sw_busy_id", out_id, 2);
    expq.push_back(2);
    expq.push_back(2);
    req = 4'b0100;
    out_ready = 1'b1;
    tick();
    chk("sw_pending", pending, 4'b0100);
    chk("sw_ovf", ovf, 4'b0000);
    chk("sw_valid_low", out_valid, 0);
    tick();
    chk("sw_regrant_valid", out_valid, 1);
    chk("sw_regrant_id", out_id, 2);
    tick();
    chk("sw_final_pending", pending, 4'b0000);
    req = 4'b0000;
    tick(2);
    chk("queue_drained", expq.size(), 0);

    // Level mode
    req1 = 4'b0010;
    out_ready1 = 1'b1;
    tick(2);
    chk("lvl_valid", out_valid1, 1);
    chk("lvl_id", out_id1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lvl_bubble", out_valid1, 0);
      chk("lvl_pending", pending1, 4'b0010);
      tick();
      chk("lvl_regrant", out_valid1, 1);
      chk("lvl_regrant_id", out_id1, 1);
      chk("lvl_ovf", ovf1, 0);
    end
    req1 = 4'b0000;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
